grid_display_scan: RTL and testbench

//  Downstream consumer of the 8x8 life-grid engine. Captures each new 64-bit generation.

---
 rtl/grid_display_scan.sv | 168 ++++++++++++++++
 tb/tb_grid_display_scan.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/grid_display_scan.sv
// Scans a captured 8x8 generation onto an LED matrix, one row at a time, blanking before each row.
// Latency: strobe in IDLE -> first lit row after 1+BLANK_CYCLES edges; all outputs registered.
// No backpressure: new generations are double-buffered and swapped in only at the frame boundary.
// Optional: define GRID_DISP_POPCOUNT_EN to add the live_count output (population of the shown frame).
module grid_display_scan #(
  parameter int ROW_CYCLES   = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_start,
  output logic        busy
`ifdef GRID_DISP_POPCOUNT_EN
  ,
  output logic [6:0]  live_count
`endif
);

  localparam int CNT_MAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] frame_buf_q, frame_buf_d;
  logic [63:0] pend_buf_q, pend_buf_d;
  logic        pending_q, pending_d;
  logic [7:0]  row_sel_q, row_sel_d;
  logic [7:0]  col_data_q, col_data_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;
  logic        idle_load;
  logic        boundary;

  // Next-state: scan sequencing, generation double-buffering and registered output values.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    cnt_d         = cnt_q;
    frame_buf_d   = frame_buf_q;
    pend_buf_d    = pend_buf_q;
    pending_d     = pending_q;
    idle_load     = 1'b0;
    boundary      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grid_valid) begin
          idle_load   = 1'b1;
          state_d     = S_BLANK;
          row_d       = 3'd0;
          cnt_d       = '0;
          frame_buf_d = grid;
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRIVE: begin
        if (cnt_q == ROW_LAST) begin
          state_d  = S_BLANK;
          cnt_d    = '0;
          row_d    = row_q + 3'd1;
          boundary = (row_q == 3'd7);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outside IDLE, strobes land in the pending buffer; the boundary promotes
    // the freshest generation, with a same-cycle strobe beating the buffer.
    if (state_q != S_IDLE) begin
      if (boundary) begin
        if (grid_valid) begin
          frame_buf_d = grid;
          pending_d   = 1'b0;
        end else if (pending_q) begin
          frame_buf_d = pend_buf_q;
          pending_d   = 1'b0;
        end
      end else if (grid_valid) begin
        pend_buf_d = grid;
        pending_d  = 1'b1;
      end
    end

    row_sel_d     = (state_d == S_DRIVE) ? (8'b1 << row_d) : 8'd0;
    col_data_d    = (state_d == S_DRIVE) ? frame_buf_d[{row_d, 3'b000} +: 8] : 8'd0;
    frame_start_d = idle_load | boundary;
    busy_d        = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      row_q         <= 3'd0;
      cnt_q         <= '0;
      frame_buf_q   <= 64'd0;
      pend_buf_q    <= 64'd0;
      pending_q     <= 1'b0;
      row_sel_q     <= 8'd0;
      col_data_q    <= 8'd0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      frame_buf_q   <= frame_buf_d;
      pend_buf_q    <= pend_buf_d;
      pending_q     <= pending_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

`ifdef GRID_DISP_POPCOUNT_EN
  logic [6:0] pop_d;
  logic [6:0] live_count_q;

  // Population count of the frame currently held for display.
  always_comb begin
    pop_d = 7'd0;
    for (int i = 0; i < 64; i++) begin
      pop_d = pop_d + 7'(frame_buf_q[i]);
    end
  end

  // Registered count, one cycle behind any frame buffer load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_count_q <= 7'd0;
    end else begin
      live_count_q <= pop_d;
    end
  end

  assign live_count = live_count_q;
`endif

endmodule

// File: tb/tb_grid_display_scan.sv
// Bench for grid_display_scan at default parameters: directed scenarios plus random strobes,
// every cycle compared against a frame-position model (position within a 144-clock frame).
module tb_grid_display_scan;

  localparam int BL    = 2;
  localparam int RC    = 16;
  localparam int SLOT  = BL + RC;
  localparam int FRAME = 8 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] grid;
  logic        grid_valid;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_start;
  logic        busy;
`ifdef GRID_DISP_POPCOUNT_EN
  logic [6:0]  live_count;
`endif

  grid_display_scan dut (
    .clk         (clk),
    .reset       (reset),
    .grid        (grid),
    .grid_valid  (grid_valid),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .busy        (busy)
`ifdef GRID_DISP_POPCOUNT_EN
    ,
    .live_count  (live_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: displayed generation, queued generation, frame position.
  bit          m_busy;
  int          m_pos;
  logic [63:0] m_frame;
  logic [63:0] m_pend;
  bit          m_pending;
  logic [6:0]  m_live;

  function automatic void model_reset();
    m_busy    = 1'b0;
    m_pos     = 0;
    m_frame   = 64'd0;
    m_pend    = 64'd0;
    m_pending = 1'b0;
    m_live    = 7'd0;
  endfunction

  function automatic void model_edge(logic v, logic [63:0] g);
    if (!reset) begin
      model_reset();
      return;
    end
    m_live = 7'($countones(m_frame));
    if (!m_busy) begin
      if (v) begin
        m_busy  = 1'b1;
        m_pos   = 0;
        m_frame = g;
      end
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      if (v) begin
        m_frame   = g;
        m_pending = 1'b0;
      end else if (m_pending) begin
        m_frame   = m_pend;
        m_pending = 1'b0;
      end
    end else begin
      m_pos = m_pos + 1;
      if (v) begin
        m_pend    = g;
        m_pending = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] exp_row_sel();
    int r;
    if (!m_busy || (m_pos % SLOT) < BL) return 8'd0;
    r = m_pos / SLOT;
    return 8'(1 << r);
  endfunction

  function automatic logic [7:0] exp_col();
    int r;
    if (!m_busy || (m_pos % SLOT) < BL) return 8'd0;
    r = m_pos / SLOT;
    return m_frame[8*r +: 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("row_sel", {56'd0, row_sel}, {56'd0, exp_row_sel()});
    chk("col_data", {56'd0, col_data}, {56'd0, exp_col()});
    chk("frame_start", {63'd0, frame_start}, {63'd0, (m_busy && m_pos == 0)});
    chk("busy", {63'd0, busy}, {63'd0, m_busy});
    chk("one_hot", {63'd0, $onehot0(row_sel)}, 64'd1);
`ifdef GRID_DISP_POPCOUNT_EN
    chk("live_count", {57'd0, live_count}, {57'd0, m_live});
`endif
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock: drive inputs away from the edge, advance model, check after the edge.
  task automatic cyc(input logic v, input logic [63:0] g);
    grid_valid = v;
    grid       = g;
    @(posedge clk);
    model_edge(v, g);
    #1;
    check_all();
  endtask

  task automatic run_to(input int target, input int budget);
    int n;
    n = 0;
    while (!(m_busy && m_pos == target) && n < budget) begin
      cyc(1'b0, rnd64());
      n++;
    end
    chk("run_to_budget", {63'd0, (m_busy && m_pos == target)}, 64'd1);
  endtask

  logic [63:0] a_gen, b_gen;
  int          lat;

  initial begin
    reset      = 1'b1;
    grid       = 64'd0;
    grid_valid = 1'b0;
    model_reset();
    #1 reset = 1'b0;

    // Reset held with random traffic: everything stays quiet.
    repeat (6) cyc(1'(($urandom & 1)), rnd64());
    #3 reset = 1'b1;
    repeat (4) cyc(1'b0, rnd64());

    // Diagonal pattern from IDLE: latency then two full frames.
    cyc(1'b1, 64'h8040201008040201);
    lat = 1;
    while (row_sel == 8'd0 && lat < 10) begin
      cyc(1'b0, rnd64());
      lat++;
    end
    chk("first_row_latency", 64'(lat), 64'd3);
    chk("first_row_sel", {56'd0, row_sel}, 64'h01);
    chk("first_col", {56'd0, col_data}, 64'h01);
    run_to(7 * SLOT + BL, 2 * FRAME);
    chk("row7_sel", {56'd0, row_sel}, 64'h80);
    chk("row7_col", {56'd0, col_data}, 64'h80);
    repeat (FRAME + 10) cyc(1'b0, rnd64());

    // Mid-frame strobe at row 3: current frame unchanged, next frame all ones.
    run_to(3 * SLOT + 5, 2 * FRAME);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_to(6 * SLOT + BL + 3, FRAME);
    chk("old_frame_row6", {56'd0, col_data}, 64'h40);
    run_to(4 * SLOT + BL, 2 * FRAME);
    chk("new_frame_row4", {56'd0, col_data}, 64'hFF);

    // A at row 5, B on the final drive cycle of row 7: B wins, A never shown.
    a_gen = 64'h1111_2222_3333_4444;
    b_gen = 64'hA5C3_0F96_5AE7_18BD;
    run_to(5 * SLOT + 4, 2 * FRAME);
    cyc(1'b1, a_gen);
    run_to(FRAME - 1, FRAME);
    cyc(1'b1, b_gen);
    chk("b_frame_start", {63'd0, frame_start}, 64'd1);
    run_to(BL, FRAME);
    chk("b_row0", {56'd0, col_data}, {56'd0, b_gen[7:0]});
    run_to(5 * SLOT + BL + 1, FRAME);
    chk("b_row5", {56'd0, col_data}, {56'd0, b_gen[47:40]});
    repeat (FRAME) cyc(1'b0, rnd64());

`ifdef GRID_DISP_POPCOUNT_EN
    run_to(FRAME - 1, 2 * FRAME);
    cyc(1'b1, 64'h0000_0000_0000_00FF);
    cyc(1'b0, rnd64());
    chk("popcount_8", {57'd0, live_count}, 64'd8);
    run_to(FRAME - 1, 2 * FRAME);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1'b0, rnd64());
    chk("popcount_64", {57'd0, live_count}, 64'd64);
`endif

    // Random strobes at low density, then a strobe every cycle.
    for (int i = 0; i < 2000; i++) cyc(1'(($urandom_range(0, 29) == 0)), rnd64());
    for (int i = 0; i < 300; i++) cyc(1'b1, rnd64());

    // Asynchronous reset during the drive of row 4.
    run_to(4 * SLOT + BL + 6, 2 * FRAME);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_row_sel", {56'd0, row_sel}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    repeat (3) cyc(1'b0, rnd64());
    reset = 1'b1;
    repeat (20) cyc(1'b0, rnd64());
    chk("idle_after_reset", {63'd0, busy}, 64'd0);
    cyc(1'b1, rnd64());
    repeat (FRAME + 20) cyc(1'(($urandom_range(0, 9) == 0)), rnd64());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
